// File: rtl/nco_quad_14b.sv
// Quadrature NCO: 32-bit phase accumulator driving a quarter-wave sine ROM, 14-bit sin/cos out.
// Define NCO_PHASE_ROUND_EN to round (instead of truncate) the accumulator to the table index.
module nco_quad_14b #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 14,
  parameter int AMP     = 8191
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic [ACC_W-1:0]   phi_inc_i,
  output logic [OUT_W-1:0]   fsin_o,
  output logic [OUT_W-1:0]   fcos_o,
  output logic               out_valid
);

  localparam int QN = 1 << (PHASE_W - 2);
  localparam int AW = PHASE_W - 1;
  localparam int MW = OUT_W - 1;
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Elaboration-time Taylor series in Q60 fixed point; precise enough that rounding is exact.
  function automatic logic [MW-1:0] quarter_sine(input int k);
    logic [127:0] x, x2, term, pos, neg, scaled;
    x    = (128'(k) * PI_Q60) >> (PHASE_W - 1);
    x2   = (x * x) >> 60;
    term = x;
    pos  = '0;
    neg  = '0;
    for (int n = 0; n < 14; n++) begin
      if (n % 2 == 0) pos = pos + term;
      else            neg = neg + term;
      term = (term * x2) >> 60;
      term = term / 128'((2 * n + 2) * (2 * n + 3));
    end
    scaled = ((pos - neg) * 128'(AMP) + (128'd1 << 59)) >> 60;
    return scaled[MW-1:0];
  endfunction

  function automatic logic [AW-1:0] fold_addr(input logic [PHASE_W-2:0] ix);
    logic [AW-1:0] r;
    r = {1'b0, ix[PHASE_W-3:0]};
    return ix[PHASE_W-2] ? (AW'(QN) - r) : r;
  endfunction

  function automatic logic [OUT_W-1:0] apply_sign(input logic [MW-1:0] mag, input logic neg);
    return neg ? (OUT_W'(0) - {1'b0, mag}) : {1'b0, mag};
  endfunction

  logic [MW-1:0] rom [0:QN];

  genvar gi;
  generate
    for (gi = 0; gi <= QN; gi++) begin : g_rom
      localparam logic [MW-1:0] QV = quarter_sine(gi);
      assign rom[gi] = QV;
    end
  endgenerate

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PHASE_W-1:0] idx_q, idx_d;
  logic [AW-1:0]      addr_s_q, addr_s_d, addr_c_q, addr_c_d;
  logic               neg_s1_q, neg_s1_d, neg_c1_q, neg_c1_d;
  logic [MW-1:0]      rom_s_q, rom_s_d, rom_c_q, rom_c_d;
  logic               neg_s2_q, neg_s2_d, neg_c2_q, neg_c2_d;
  logic [OUT_W-1:0]   fsin_q, fsin_d, fcos_q, fcos_d;
  logic [1:0]         fill_q, fill_d;
  logic               valid_q, valid_d;
  logic [ACC_W-1:0]   acc_rnd;
  logic [PHASE_W-1:0] idx_c;

  always_comb begin
`ifdef NCO_PHASE_ROUND_EN
    acc_rnd = acc_q + (ACC_W'(1) << (ACC_W - PHASE_W - 1));
`else
    acc_rnd = acc_q;
`endif
    idx_c = idx_q + PHASE_W'(QN);
  end

  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    addr_s_d = addr_s_q;
    addr_c_d = addr_c_q;
    neg_s1_d = neg_s1_q;
    neg_c1_d = neg_c1_q;
    rom_s_d  = rom_s_q;
    rom_c_d  = rom_c_q;
    neg_s2_d = neg_s2_q;
    neg_c2_d = neg_c2_q;
    fsin_d   = fsin_q;
    fcos_d   = fcos_q;
    fill_d   = fill_q;
    valid_d  = valid_q;
    if (clken) begin
      acc_d    = acc_q + phi_inc_i;
      idx_d    = acc_rnd[ACC_W-1 -: PHASE_W];
      addr_s_d = fold_addr(idx_q[PHASE_W-2:0]);
      neg_s1_d = idx_q[PHASE_W-1];
      addr_c_d = fold_addr(idx_c[PHASE_W-2:0]);
      neg_c1_d = idx_c[PHASE_W-1];
      rom_s_d  = rom[addr_s_q];
      rom_c_d  = rom[addr_c_q];
      neg_s2_d = neg_s1_q;
      neg_c2_d = neg_c1_q;
      // Pipeline contents before the fourth edge are reset leftovers; keep outputs at 0.
      if (fill_q == 2'd3) begin
        fsin_d  = apply_sign(rom_s_q, neg_s2_q);
        fcos_d  = apply_sign(rom_c_q, neg_c2_q);
        valid_d = 1'b1;
      end else begin
        fill_d  = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      idx_q    <= '0;
      addr_s_q <= '0;
      addr_c_q <= '0;
      neg_s1_q <= 1'b0;
      neg_c1_q <= 1'b0;
      rom_s_q  <= '0;
      rom_c_q  <= '0;
      neg_s2_q <= 1'b0;
      neg_c2_q <= 1'b0;
      fsin_q   <= '0;
      fcos_q   <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      addr_s_q <= addr_s_d;
      addr_c_q <= addr_c_d;
      neg_s1_q <= neg_s1_d;
      neg_c1_q <= neg_c1_d;
      rom_s_q  <= rom_s_d;
      rom_c_q  <= rom_c_d;
      neg_s2_q <= neg_s2_d;
      neg_c2_q <= neg_c2_d;
      fsin_q   <= fsin_d;
      fcos_q   <= fcos_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
    end
  end

  assign fsin_o    = fsin_q;
  assign fcos_o    = fcos_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_nco_quad_14b.sv
// Bench for nco_quad_14b: directed vector table, hand-written corner sequences and a
// random run, all checked against a floating-point sine/cosine reference of the phase sequence.
module tb_nco_quad_14b;

  logic        clk;
  logic        reset_n;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic [13:0] fsin_o;
  logic [13:0] fcos_o;
  logic        out_valid;

  nco_quad_14b dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [13:0] s;
    logic [13:0] c;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: phase of sample n is the sum of increments on the first n enabled edges.
  logic [31:0] m_acc;
  logic [31:0] m_phase[$];
  int          m_edges;

  function automatic logic [13:0] ref_val(input logic [31:0] p, input bit is_cos);
    logic [31:0] pr;
    int          idx;
    int          r;
    real         a;
    real         v;
`ifdef NCO_PHASE_ROUND_EN
    pr = p + 32'h0008_0000;
`else
    pr = p;
`endif
    idx = int'(pr[31:20]);
    a   = 2.0 * 3.14159265358979323846 * real'(idx) / 4096.0;
    v   = 8191.0 * (is_cos ? $cos(a) : $sin(a));
    if (v >= 0.0) r = $rtoi($floor(v + 0.5));
    else          r = -$rtoi($floor(-v + 0.5));
    return 14'(r);
  endfunction

  task automatic model_clear();
    m_acc   = 32'd0;
    m_phase.delete();
    m_edges = 0;
  endtask

  task automatic check(input string name, input logic [13:0] es, input logic [13:0] ec,
                       input logic ev, input bit verbose);
    n_cmp++;
    if (fsin_o !== es || fcos_o !== ec || out_valid !== ev) begin
      n_err++;
      $display("FAIL %s edge=%0d sin got %0d want %0d, cos got %0d want %0d, valid got %0b want %0b",
               name, m_edges, $signed(fsin_o), $signed(es), $signed(fcos_o), $signed(ec),
               out_valid, ev);
    end else if (verbose) begin
      $display("ok   %s edge=%0d sin=%0d cos=%0d valid=%0b",
               name, m_edges, $signed(fsin_o), $signed(fcos_o), out_valid);
    end
  endtask

  task automatic check_model(input string name);
    if (m_edges < 4) check(name, 14'd0, 14'd0, 1'b0, 1'b0);
    else check(name, ref_val(m_phase[m_edges-4], 1'b0), ref_val(m_phase[m_edges-4], 1'b1),
               1'b1, 1'b0);
  endtask

  task automatic step(input logic en, input logic [31:0] inc, input string name);
    clken     = en;
    phi_inc_i = inc;
    @(posedge clk);
    if (en) begin
      m_phase.push_back(m_acc);
      m_acc = m_acc + inc;
      m_edges++;
    end
    @(negedge clk);
    check_model(name);
  endtask

  task automatic do_reset(input logic [31:0] inc);
    reset_n   = 1'b0;
    clken     = 1'b1;
    phi_inc_i = inc;
    model_clear();
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  localparam logic [31:0] INC_1PCT = 32'h028F_5C29;
  localparam logic [31:0] INC_HALF = 32'h8000_0000;
  localparam logic [31:0] INC_TBL  = 32'h0010_0000;

  initial begin
    vec_t        vecs[5];
    logic [31:0] rinc;
    logic        ren;

    vecs[0] = '{0,   14'd0,    14'd8191};
    vecs[1] = '{25,  14'd8191, 14'd0};
    vecs[2] = '{50,  14'd0,    14'h2001};
    vecs[3] = '{75,  14'h2001, 14'd0};
    vecs[4] = '{100, 14'd0,    14'd8191};

    reset_n   = 1'b0;
    clken     = 1'b0;
    phi_inc_i = 32'd0;
    model_clear();

    // Reset and pipeline fill at 0.01 f_clk
    do_reset(INC_1PCT);
    check("reset_state", 14'd0, 14'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, INC_1PCT, "fill");
      check("fill_zero", 14'd0, 14'd0, 1'b0, 1'b1);
    end

    // Vector table: sample n lands on enabled edge 4+n
    for (int v = 0; v < 5; v++) begin
      while (m_edges < 4 + vecs[v].n) step(1'b1, INC_1PCT, "run_1pct");
      check($sformatf("vec_n%0d", vecs[v].n), vecs[v].s, vecs[v].c, 1'b1, 1'b1);
    end

    // clken gap: everything frozen, then resumes without skipping a sample
    repeat (3) step(1'b1, INC_1PCT, "pre_gap");
    for (int k = 0; k < 5; k++) step(1'b0, INC_1PCT ^ 32'h1234_5678, "gap");
    $display("ok   clken gap done at edge=%0d", m_edges);
    repeat (12) step(1'b1, INC_1PCT, "post_gap");

    // Half-rate wrap alternates between phase 0 and phase pi
    do_reset(INC_HALF);
    repeat (3) step(1'b1, INC_HALF, "wrap_fill");
    for (int k = 0; k < 8; k++) begin
      step(1'b1, INC_HALF, "wrap_run");
      if (k % 2 == 0) check("wrap_even", 14'd0, 14'd8191, 1'b1, 1'b1);
      else            check("wrap_odd",  14'd0, 14'h2001, 1'b1, 1'b1);
    end

    // Asynchronous reset between edges
    repeat (5) step(1'b1, INC_1PCT, "pre_areset");
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("async_reset", 14'd0, 14'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("async_hold", 14'd0, 14'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    repeat (3) step(1'b1, INC_1PCT, "refill");
    check("refill_zero", 14'd0, 14'd0, 1'b0, 1'b1);
    step(1'b1, INC_1PCT, "restart");
    check("restart_s0", 14'd0, 14'd8191, 1'b1, 1'b1);
    repeat (10) step(1'b1, INC_1PCT, "restart_run");

    // Every table point once
    do_reset(INC_TBL);
    repeat (4096 + 4) step(1'b1, INC_TBL, "exhaustive");
    $display("ok   exhaustive sweep done at edge=%0d", m_edges);

    // Random increments and random enable
    rinc = $urandom;
    do_reset(rinc);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 39) == 0) rinc = $urandom;
      ren = ($urandom_range(0, 3) != 0);
      step(ren, rinc, "random");
    end
    $display("ok   random run done at edge=%0d", m_edges);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nco_quad_14b.md
Name: nco_quad_14b

Overview:
- Numerically controlled oscillator producing quadrature sine/cosine samples as 14-bit two's complement values.
- A 32-bit phase accumulator advances by phi_inc_i on each enabled clock, so the output frequency is f_clk·phi_inc_i/2^32.
- The accumulated phase addresses a quarter-wave sine table.
- Sits in the DAC signal path as the tone/carrier source.

Parameters:
- ACC_W, 32, phase accumulator and phi_inc_i width.
- PHASE_W, 12, phase bits kept for table lookup (4096 points per cycle).
- OUT_W, 14, output sample width (two's complement).
- AMP, 8191, peak output magnitude (2^(OUT_W-1)-1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- clken  in  1  clock enable; 0 freezes all state.
- phi_inc_i  in  32  phase increment, unsigned; sampled every enabled cycle.
- fsin_o  out  14  sine sample, two's complement, registered.
- fcos_o  out  14  cosine sample, two's complement, registered.
- out_valid  out  1  registered; high once the pipeline holds valid samples.

Behaviour:
- Reset (reset_n=0, async, any time including mid-operation):
  - acc, all pipeline registers, fsin_o, fcos_o, out_valid = 0.
  - The fill counter clears.
- Accumulator: on each enabled edge, acc <= acc + phi_inc_i, modulo 2^32, with free wrap-around and no overflow flag.
- Sample numbering: sample n is taken at phase P(n) = n·phi_inc_i mod 2^32, so sample 0 has phase 0.
  - For a changed phi_inc_i, the new increment applies from the next enabled edge.
- Phase index: i = P[31:20], a truncation. q = i[11:10], r = i[9:0].
- Table: Q[k] = round(8191·sin(2π·k/4096)) for k = 0..1024 (1025 entries); Q[0]=0, Q[1024]=8191.
  - Contents are computed offline and held as a constant ROM.
- Sine mapping:
  - q=0: Q[r]
  - q=1: Q[1024-r]
  - q=2: -Q[r]
  - q=3: -Q[1024-r]
- Cosine: the same mapping applied to index (i+1024) mod 4096.
- Result: fsin_o = round(8191·sin(2πi/4096)) exactly, and fcos_o likewise for cos.
  - Outputs never take the value -8192.
  - Negation of 0 yields 0.
- Pipeline, counted in enabled cycles only:
  - Stage 1: acc register.
  - Stage 2: quadrant/address register.
  - Stage 3: ROM read.
  - Stage 4: sign apply and output register.
  - Sample n appears at the outputs on the 4+n-th enabled edge after reset release.
- out_valid:
  - A saturating fill counter counts enabled edges after reset release.
  - out_valid goes 1 on the 4th enabled edge, the same edge sample 0 appears.
  - It then stays 1 until reset.
  - Before that edge, outputs remain 0.
- clken=0: acc, pipeline, counter and outputs all hold their values, and out_valid holds.
- Simultaneous reset and clken: reset wins.

Optional Feature:
- Macro: NCO_PHASE_ROUND_EN.
- Defined: the phase index is rounded, i = (P + 2^19)[31:20] mod 4096. This halves the worst-case phase error; latency is unchanged.
- Undefined: the truncation described under Behaviour applies.

Test Plan:
- Reset/fill: hold reset_n=0 for 7 cycles with clken=1 and phi_inc_i=0x028F5C29, then release.
  - Required: out_valid=0 and outputs 0 for 3 edges.
  - On the 4th edge: out_valid=1, fsin_o=0, fcos_o=8191.
- Frequency 0.01·f_clk: phi_inc_i=0x028F5C29, free run.
  - Sample 25 (phase 0x40000001, i=1024): fsin_o=8191, fcos_o=0.
  - Sample 50 (i=2048): fsin_o=0, fcos_o=-8191 (14'h2001).
  - Sample 75: fsin_o=-8191, fcos_o=0.
  - Sample 100 (phase 4): fsin_o=0, fcos_o=8191.
- Wrap: phi_inc_i=0x80000000.
  - Outputs alternate (0, 8191) and (0, -8191) every enabled cycle.
- clken gating: drop clken for 5 cycles mid-stream.
  - Required: outputs and out_valid frozen during the gap.
  - The sample sequence resumes with no missing or duplicated samples.
- Async reset mid-run: assert reset_n between clock edges.
  - Required: outputs and out_valid go to 0 immediately.
  - After release, the sequence restarts from sample 0 with the 4-cycle fill.
- Exhaustive table check: phi_inc_i=0x00100000.
  - Every sample n=0..4095 equals round(8191·sin/cos(2πn/4096)).
